bundler_sched: RTL and testbench

Sequencer for the bundler input slicer: drives its 2-bit `state` and `d` slice offset so that all `DIMENSIONS` bits of the encoded hypervector array are streamed into the bundler in `PAR_BITS`-wide chunks. It sits between the top-level encoder control, which issues start/abort, and the slicer/bundler pair, which supplies back-pressure via `ready`. It reports completion with a single-cycle `done` pulse.

---
 rtl/bundler_sched_if.sv | 26 ++
 rtl/bundler_sched.sv | 88 ++++++++
 tb/tb_bundler_sched.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bundler_sched_if.sv
// Handshake and slice-offset bundle between the encoder control, bundler_sched
// and the bundler input slicer.
interface bundler_sched_if #(
    parameter int unsigned DIMENSIONS = 10000
);
    localparam int unsigned DW = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;

    logic          start;
    logic          abort;
    logic          ready;
    logic [1:0]    state;
    logic [DW-1:0] d;
    logic          last;
    logic          busy;
    logic          done;

    // master: the sequencer itself; slave: the control/slicer side feeding it
    modport master (
        input  start, abort, ready,
        output state, d, last, busy, done
    );
    modport slave (
        output start, abort, ready,
        input  state, d, last, busy, done
    );
endinterface

// File: rtl/bundler_sched.sv
// Streams DIMENSIONS bits into the bundler as PAR_BITS-wide chunks by stepping
// the slicer offset d under ready back-pressure; one-cycle done on completion.
module bundler_sched #(
    parameter int unsigned DIMENSIONS = 10000,
    parameter int unsigned PAR_BITS   = 10
) (
    input  logic            clk,
    input  logic            rst,
    bundler_sched_if.master bus
);
    localparam int unsigned DW = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;

    if (PAR_BITS < 1 || PAR_BITS > DIMENSIONS) begin : g_bad_par
        $error("bundler_sched: PAR_BITS must be in 1..DIMENSIONS");
    end else if (DIMENSIONS % PAR_BITS != 0) begin : g_bad_mult
        $error("bundler_sched: DIMENSIONS must be a multiple of PAR_BITS");
    end

    // Offset of the final chunk; the step is one bit wider so that a
    // PAR_BITS equal to a power-of-two DIMENSIONS still fits.
    localparam logic [DW-1:0] D_LAST = DW'(DIMENSIONS - PAR_BITS);
    localparam logic [DW:0]   D_STEP = (DW + 1)'(PAR_BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] d_q, d_d;
    logic [DW:0]   d_inc;
    logic          at_last;

    assign d_inc   = {1'b0, d_q} + D_STEP;
    assign at_last = (d_q == D_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        d_d     = d_q;
        unique case (state_q)
            ST_IDLE: begin
                d_d = '0;
                if (bus.start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    d_d     = '0;
                end else if (bus.ready && at_last) begin
                    state_d = ST_DONE;
                    d_d     = '0;
                end else if (bus.ready) begin
                    d_d = DW'(d_inc);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                d_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                d_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
        end
    end

    // Outputs decode registered state only; no input reaches them combinationally.
    assign bus.state = state_q;
    assign bus.d     = d_q;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.last  = (state_q == ST_RUN) && at_last;
endmodule

// File: tb/tb_bundler_sched.sv
// Directed plus randomized bench for bundler_sched against a chunk-index model,
// with a 100/10 instance and a single-chunk 16/16 instance.
module tb_bundler_sched;
    localparam int A_DIM = 100;
    localparam int A_PAR = 10;
    localparam int B_DIM = 16;
    localparam int B_PAR = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bundler_sched_if #(.DIMENSIONS(A_DIM)) bus_a ();
    bundler_sched_if #(.DIMENSIONS(B_DIM)) bus_b ();

    bundler_sched #(.DIMENSIONS(A_DIM), .PAR_BITS(A_PAR)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.master));
    bundler_sched #(.DIMENSIONS(B_DIM), .PAR_BITS(B_PAR)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.master));

    // Model: phase (0 idle, 1 run, 2 done) and index of the chunk on offer.
    typedef struct {
        int st;
        int chunk;
        int k;
        int p;
    } model_t;

    model_t m_a, m_b;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int run_cnt, last_cnt, done_cnt, idle_cnt, done_cyc, start_cyc, b_done_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic model_t step(model_t m, logic r, logic s, logic a, logic rd);
        model_t n = m;
        if (r) begin
            n.st = 0; n.chunk = 0;
        end else begin
            case (m.st)
                0: if (s) begin n.st = 1; n.chunk = 0; end
                1: begin
                    if (a) begin
                        n.st = 0; n.chunk = 0;
                    end else if (rd) begin
                        if (m.chunk == m.k - 1) begin n.st = 2; n.chunk = 0; end
                        else n.chunk = m.chunk + 1;
                    end
                end
                default: begin n.st = 0; n.chunk = 0; end
            endcase
        end
        return n;
    endfunction

    task automatic compare(input string who, input model_t m, input logic [1:0] st,
                           input logic [31:0] d, input logic last, input logic busy,
                           input logic done);
        check({who, ".state"}, 32'(st), m.st);
        check({who, ".d"}, d, m.chunk * m.p);
        check({who, ".last"}, 32'(last), (m.st == 1 && m.chunk == m.k - 1) ? 1 : 0);
        check({who, ".busy"}, 32'(busy), (m.st == 1) ? 1 : 0);
        check({who, ".done"}, 32'(done), (m.st == 2) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        m_a = step(m_a, rst, bus_a.start, bus_a.abort, bus_a.ready);
        m_b = step(m_b, rst, bus_b.start, bus_b.abort, bus_b.ready);
        #1;
        cyc++;
        compare("a", m_a, bus_a.state, 32'(bus_a.d), bus_a.last, bus_a.busy, bus_a.done);
        compare("b", m_b, bus_b.state, 32'(bus_b.d), bus_b.last, bus_b.busy, bus_b.done);
        if (bus_a.state === 2'd1) run_cnt++;
        if (bus_a.state === 2'd0) idle_cnt++;
        if (bus_a.last === 1'b1) last_cnt++;
        if (bus_a.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (bus_b.done === 1'b1) b_done_cnt++;
    endtask

    task automatic clear_counts();
        run_cnt = 0; last_cnt = 0; done_cnt = 0; idle_cnt = 0; done_cyc = -1; b_done_cnt = 0;
    endtask

    task automatic drive_idle();
        bus_a.start = 0; bus_a.abort = 0; bus_a.ready = 0;
        bus_b.start = 0; bus_b.abort = 0; bus_b.ready = 0;
    endtask

    initial begin
        int s40, s90;
        m_a = '{0, 0, A_DIM / A_PAR, A_PAR};
        m_b = '{0, 0, B_DIM / B_PAR, B_PAR};
        clear_counts();
        rst = 1;
        drive_idle();

        // Reset for 3 cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            bus_a.start = 1'($urandom); bus_a.abort = 1'($urandom); bus_a.ready = 1'($urandom);
            bus_b.start = 1'($urandom); bus_b.abort = 1'($urandom); bus_b.ready = 1'($urandom);
            tick();
        end
        check("reset.state", 32'(bus_a.state), 0);
        check("reset.d", 32'(bus_a.d), 0);
        rst = 0;
        drive_idle();
        tick();

        // Full pass without stalls
        clear_counts();
        bus_a.start = 1;
        tick();
        start_cyc = cyc;
        bus_a.start = 0;
        bus_a.ready = 1;
        repeat (12) tick();
        check("full.run_cycles", run_cnt, 10);
        check("full.last_cycles", last_cnt, 1);
        check("full.done_pulses", done_cnt, 1);
        check("full.done_latency", done_cyc - start_cyc, 10);
        check("full.end_state", 32'(bus_a.state), 0);
        bus_a.ready = 0;

        // Single-chunk instance
        bus_b.start = 1;
        tick();
        bus_b.start = 0;
        check("single.first_last", 32'(bus_b.last), 1);
        check("single.first_d", 32'(bus_b.d), 0);
        bus_b.ready = 1;
        tick();
        check("single.done", 32'(bus_b.done), 1);
        bus_b.ready = 0;
        tick();
        check("single.idle", 32'(bus_b.state), 0);

        // Back-pressure: 3 stalls at d=40, 1 stall at d=90
        clear_counts();
        bus_a.start = 1;
        tick();
        start_cyc = cyc;
        bus_a.start = 0;
        s40 = 0; s90 = 0;
        repeat (18) begin
            bus_a.ready = 1;
            if (m_a.st == 1 && m_a.chunk == 4 && s40 < 3) begin
                bus_a.ready = 0; s40++;
            end else if (m_a.st == 1 && m_a.chunk == 9 && s90 < 1) begin
                bus_a.ready = 0; s90++;
            end
            tick();
        end
        check("stall.run_cycles", run_cnt, 14);
        check("stall.last_cycles", last_cnt, 2);
        check("stall.done_pulses", done_cnt, 1);
        check("stall.done_latency", done_cyc - start_cyc, 14);
        bus_a.ready = 0;

        // Abort together with ready at d=50, then a fresh pass
        clear_counts();
        bus_a.start = 1;
        tick();
        bus_a.start = 0;
        bus_a.ready = 1;
        for (int i = 0; i < 20 && !(m_a.st == 1 && m_a.chunk == 5); i++) tick();
        check("abort.at_d50", 32'(bus_a.d), 50);
        bus_a.abort = 1;
        tick();
        bus_a.abort = 0;
        check("abort.state", 32'(bus_a.state), 0);
        check("abort.d", 32'(bus_a.d), 0);
        check("abort.no_done", done_cnt, 0);
        bus_a.start = 1;
        tick();
        bus_a.start = 0;
        check("abort.restart_state", 32'(bus_a.state), 1);
        check("abort.restart_d", 32'(bus_a.d), 0);
        repeat (12) tick();
        check("abort.restart_done", done_cnt, 1);
        bus_a.ready = 0;

        // Start held high through RUN and DONE
        clear_counts();
        bus_a.start = 1;
        bus_a.ready = 1;
        repeat (13) tick();
        bus_a.start = 0;
        check("hold.run_cycles", run_cnt, 11);
        check("hold.done_pulses", done_cnt, 1);
        check("hold.idle_cycles", idle_cnt, 1);
        check("hold.second_pass", 32'(bus_a.d), 0);

        // Reset in the middle of the pass at d=70
        for (int i = 0; i < 20 && !(m_a.st == 1 && m_a.chunk == 7); i++) tick();
        check("rst70.at_d70", 32'(bus_a.d), 70);
        rst = 1;
        tick();
        rst = 0;
        check("rst70.state", 32'(bus_a.state), 0);
        check("rst70.d", 32'(bus_a.d), 0);
        check("rst70.last", 32'(bus_a.last), 0);
        check("rst70.busy", 32'(bus_a.busy), 0);
        check("rst70.done", 32'(bus_a.done), 0);
        drive_idle();
        tick();

        // Randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(63) == 0);
            bus_a.start = ($urandom_range(3) == 0);
            bus_a.abort = ($urandom_range(15) == 0);
            bus_a.ready = ($urandom_range(3) != 0);
            bus_b.start = ($urandom_range(3) == 0);
            bus_b.abort = ($urandom_range(7) == 0);
            bus_b.ready = ($urandom_range(1) == 0);
            tick();
        end
        rst = 0;
        drive_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
